dmem_arbiter: RTL and testbench

// - Shares the single-port data memory between two requesters: port 0 (CPU load/store unit)
//   and port 1 (debug/loader master). Sits between both requesters and the memory.
// - Round-robin arbitration, one access in flight, registered grant and read-response handshake.
// - Forwards address, write data and size control (DMCTRL encoding) unchanged to memory.

---
 rtl/dmem_arbiter.sv | 191 +++++++++++++++++++
 tb/tb_dmem_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU LSU (port 0) and the
// debug/loader master (port 1). Define DMEM_ARB_CHECK_EN to flag out-of-range/misaligned accesses.
module dmem_arbiter #(
  parameter int MEM_WORDS = 32,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [31:0]       p0_wdata,
  input  logic [2:0]        p0_ctrl,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [31:0]       p0_rdata,
  output logic              p0_err,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [31:0]       p1_wdata,
  input  logic [2:0]        p1_ctrl,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [31:0]       p1_rdata,
  output logic              p1_err,
  output logic [ADDR_W-1:0] mem_address,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_ctrl,
  output logic              mem_write,
  input  logic [31:0]       mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2} state_t;

  state_t            state_q, state_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic              bad_q, bad_d;
  logic [ADDR_W-1:0] mem_address_q, mem_address_d;
  logic [31:0]       mem_wdata_q, mem_wdata_d;
  logic [2:0]        mem_ctrl_q, mem_ctrl_d;
  logic              mem_write_q, mem_write_d;
  logic [1:0]        gnt_q, gnt_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [1:0]        err_q, err_d;
  logic [1:0][31:0]  rdata_q, rdata_d;

  logic [1:0]        req;
  logic              win;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [31:0]       win_wdata;
  logic [2:0]        win_ctrl;
  logic              win_bad;

  assign req = {p1_req, p0_req};

  // rr_ptr_q names the port preferred on a tie; it always points away from the last winner.
  always_comb begin
    if (req == 2'b11) begin
      win = rr_ptr_q;
    end else begin
      win = req[1];
    end
  end

  assign win_we    = win ? p1_we    : p0_we;
  assign win_addr  = win ? p1_addr  : p0_addr;
  assign win_wdata = win ? p1_wdata : p0_wdata;
  assign win_ctrl  = win ? p1_ctrl  : p0_ctrl;

`ifdef DMEM_ARB_CHECK_EN
  localparam logic [ADDR_W:0] MEM_BYTES = (ADDR_W+1)'(4 * MEM_WORDS);

  always_comb begin
    win_bad = 1'b0;
    if ({1'b0, win_addr} >= MEM_BYTES) begin
      win_bad = 1'b1;
    end
    if ((win_ctrl == 3'b001 || win_ctrl == 3'b101) && win_addr[0]) begin
      win_bad = 1'b1;
    end
    if (win_ctrl == 3'b010 && win_addr[1:0] != 2'b00) begin
      win_bad = 1'b1;
    end
    // Unsigned encodings only make sense for loads.
    if (win_we && (win_ctrl == 3'b100 || win_ctrl == 3'b101)) begin
      win_bad = 1'b1;
    end
  end
`else
  assign win_bad = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    sel_d         = sel_q;
    we_d          = we_q;
    bad_d         = bad_q;
    mem_address_d = mem_address_q;
    mem_wdata_d   = mem_wdata_q;
    mem_ctrl_d    = mem_ctrl_q;
    mem_write_d   = 1'b0;
    gnt_d         = 2'b00;
    rvalid_d      = 2'b00;
    err_d         = 2'b00;
    rdata_d       = rdata_q;

    case (state_q)
      IDLE, RESP: begin
        if (|req) begin
          state_d       = ACCESS;
          rr_ptr_d      = ~win;
          sel_d         = win;
          we_d          = win_we;
          bad_d         = win_bad;
          mem_address_d = win_addr;
          mem_wdata_d   = win_wdata;
          mem_ctrl_d    = win_ctrl;
          mem_write_d   = win_we & ~win_bad;
          gnt_d[win]    = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        state_d         = RESP;
        rvalid_d[sel_q] = 1'b1;
        err_d[sel_q]    = bad_q;
        // Memory read data is combinational, so it is valid at the edge closing ACCESS.
        if (!we_q && !bad_q) begin
          rdata_d[sel_q] = mem_rdata;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      rr_ptr_q      <= 1'b0;
      sel_q         <= 1'b0;
      we_q          <= 1'b0;
      bad_q         <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      mem_ctrl_q    <= '0;
      mem_write_q   <= 1'b0;
      gnt_q         <= 2'b00;
      rvalid_q      <= 2'b00;
      err_q         <= 2'b00;
      rdata_q       <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      sel_q         <= sel_d;
      we_q          <= we_d;
      bad_q         <= bad_d;
      mem_address_q <= mem_address_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_ctrl_q    <= mem_ctrl_d;
      mem_write_q   <= mem_write_d;
      gnt_q         <= gnt_d;
      rvalid_q      <= rvalid_d;
      err_q         <= err_d;
      rdata_q       <= rdata_d;
    end
  end

  assign p0_gnt      = gnt_q[0];
  assign p1_gnt      = gnt_q[1];
  assign p0_rvalid   = rvalid_q[0];
  assign p1_rvalid   = rvalid_q[1];
  assign p0_err      = err_q[0];
  assign p1_err      = err_q[1];
  assign p0_rdata    = rdata_q[0];
  assign p1_rdata    = rdata_q[1];
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_ctrl    = mem_ctrl_q;
  assign mem_write   = mem_write_q;
  assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: two requesters, a byte-lane memory, and a
// transaction-level reference (who wins, when, and what data each port sees).
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  always #5 clk = ~clk;

  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [2:0]  p0_ctrl, p1_ctrl;
  logic        p0_gnt, p0_rvalid, p0_err, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_address, mem_wdata, mem_rdata;
  logic [2:0]  mem_ctrl;
  logic        mem_write, busy;

  dmem_arbiter #(.MEM_WORDS(32), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_ctrl(p0_ctrl),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_ctrl(p1_ctrl),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_ctrl(mem_ctrl),
    .mem_write(mem_write), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [2:0] c, logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (c)
      3'b000:  r[int'(a)*8 +: 8] = wd[7:0];
      3'b001:  r[int'(a[1])*16 +: 16] = wd[15:0];
      3'b010:  r = wd;
      default: ;
    endcase
    return r;
  endfunction

  function automatic logic is_bad(logic we, logic [31:0] a, logic [2:0] c);
`ifdef DMEM_ARB_CHECK_EN
    return (a >= 32'd128) || ((c == 3'b001 || c == 3'b101) && a[0]) ||
           (c == 3'b010 && a[1:0] != 2'b00) || (we && (c == 3'b100 || c == 3'b101));
`else
    return 1'b0;
`endif
  endfunction

  // Memory: combinational read, byte-lane write; ld_* preloads it during reset.
  logic [31:0] mem [32];
  logic        ld_en;
  logic [4:0]  ld_idx;
  logic [31:0] ld_val;
  assign mem_rdata = mem[mem_address[6:2]];
  always @(posedge clk) begin
    if (mem_write) mem[mem_address[6:2]] <= merge(mem[mem_address[6:2]], mem_wdata, mem_ctrl, mem_address[1:0]);
    else if (ld_en) mem[ld_idx] <= ld_val;
  end

  int          checks = 0;
  int          failures = 0;
  logic [31:0] ref_mem [32];
  logic [1:0]  pend;
  logic        pwe [2];
  logic [31:0] paddr [2];
  logic [31:0] pwdata [2];
  logic [2:0]  pctrl [2];
  logic [1:0]  exp_gnt, exp_rv;
  int          last_win;
  int          f_port;
  logic        f_we, f_bad;
  logic [31:0] f_addr, f_wdata;
  logic [2:0]  f_ctrl;
  logic [31:0] exp_rdata [2];
  logic        exp_err [2];
  int          wait_cnt [2];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_inputs();
    p0_req = pend[0]; p0_we = pwe[0]; p0_addr = paddr[0]; p0_wdata = pwdata[0]; p0_ctrl = pctrl[0];
    p1_req = pend[1]; p1_we = pwe[1]; p1_addr = paddr[1]; p1_wdata = pwdata[1]; p1_ctrl = pctrl[1];
  endtask

  task automatic model_reset();
    exp_gnt = 2'b00; exp_rv = 2'b00; last_win = -1;
    f_port = 0; f_we = 1'b0; f_bad = 1'b0; f_addr = '0; f_wdata = '0; f_ctrl = '0;
    for (int i = 0; i < 2; i++) begin
      exp_rdata[i] = '0; exp_err[i] = 1'b0; wait_cnt[i] = 0;
      pwe[i] = 1'b0; paddr[i] = '0; pwdata[i] = '0; pctrl[i] = '0;
    end
    pend = 2'b00;
  endtask

  task automatic new_txn(input int p, input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] c);
    pend[p] = 1'b1; pwe[p] = we; paddr[p] = a; pwdata[p] = wd; pctrl[p] = c;
  endtask

  task automatic rand_txn(input int p);
    logic [2:0]  c;
    logic [31:0] a;
    case ($urandom_range(0, 4))
      0: c = 3'b000;
      1: c = 3'b001;
      2: c = 3'b010;
      3: c = 3'b100;
      default: c = 3'b101;
    endcase
    a = 32'($urandom_range(0, 127));
    if ($urandom_range(0, 3) != 0) begin
      if (c[1:0] == 2'b10) a[1:0] = 2'b00;
      if (c[1:0] == 2'b01) a[0] = 1'b0;
    end
    if ($urandom_range(0, 9) == 0) a = a + 32'd128;
    new_txn(p, 1'($urandom_range(0, 1)), a, $urandom, c);
  endtask

  task automatic check_outputs();
    check_val("gnt", {30'b0, p1_gnt, p0_gnt}, {30'b0, exp_gnt});
    check_val("rvalid", {30'b0, p1_rvalid, p0_rvalid}, {30'b0, exp_rv});
    check_val("busy", {31'b0, busy}, {31'b0, (exp_gnt != 2'b00) || (exp_rv != 2'b00)});
    check_val("mem_write", {31'b0, mem_write}, {31'b0, (exp_gnt != 2'b00) && f_we && !f_bad});
    check_val("mem_address", mem_address, f_addr);
    check_val("mem_wdata", mem_wdata, f_wdata);
    check_val("mem_ctrl", {29'b0, mem_ctrl}, {29'b0, f_ctrl});
    check_val("p0_rdata", p0_rdata, exp_rdata[0]);
    check_val("p1_rdata", p1_rdata, exp_rdata[1]);
    check_val("p0_err", {31'b0, p0_err}, {31'b0, exp_rv[0] && exp_err[0]});
    check_val("p1_err", {31'b0, p1_err}, {31'b0, exp_rv[1] && exp_err[1]});
  endtask

  // One clock of the reference: an arbitration happens on any edge not closing a granted cycle.
  task automatic step();
    int         win;
    logic [1:0] nxt_gnt;
    @(posedge clk);
    nxt_gnt = 2'b00;
    if (exp_gnt != 2'b00) begin
      if (!f_bad) begin
        if (f_we) ref_mem[f_addr[6:2]] = merge(ref_mem[f_addr[6:2]], f_wdata, f_ctrl, f_addr[1:0]);
        else exp_rdata[f_port] = ref_mem[f_addr[6:2]];
      end
      exp_err[f_port] = f_bad;
      pend[f_port] = 1'b0;
    end else if (pend != 2'b00) begin
      if (pend == 2'b11) win = (last_win == 0) ? 1 : 0;
      else win = pend[1] ? 1 : 0;
      check_val("starve_wait", {31'b0, wait_cnt[win] > 2}, 32'd0);
      wait_cnt[win] = 0;
      if (pend[1-win]) wait_cnt[1-win]++;
      last_win = win;
      nxt_gnt[win] = 1'b1;
      f_port = win; f_we = pwe[win]; f_addr = paddr[win]; f_wdata = pwdata[win]; f_ctrl = pctrl[win];
      f_bad = is_bad(f_we, f_addr, f_ctrl);
    end
    exp_rv = exp_gnt;
    exp_gnt = nxt_gnt;
    #1;
    check_outputs();
    $display("cycle t=%0t gnt=%b rvalid=%b addr=%08h we=%b ctrl=%03b", $time, exp_gnt, exp_rv, f_addr, f_we, f_ctrl);
    apply_inputs();
  endtask

  initial begin
    logic [31:0] v;
    logic [31:0] old_word;
    rst = 1'b1;
    ld_en = 1'b0; ld_idx = '0; ld_val = '0;
    model_reset();
    apply_inputs();
    for (int i = 0; i < 32; i++) begin
      v = (i == 2) ? 32'hDEADBEEF : $urandom;
      ref_mem[i] = v;
      ld_en = 1'b1; ld_idx = 5'(i); ld_val = v;
      @(posedge clk);
      #1;
    end
    ld_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_outputs();

    // Load word from address 0x08.
    new_txn(0, 1'b0, 32'h08, 32'h0, 3'b010);
    apply_inputs();
    step();
    step();
    check_val("lw_rdata", p0_rdata, 32'hDEADBEEF);
    step();

    // Store byte to 0x05.
    new_txn(0, 1'b1, 32'h05, 32'h000000AB, 3'b000);
    apply_inputs();
    step();
    check_val("sb_write", {31'b0, mem_write}, 32'd1);
    step();
    step();
    check_val("sb_mem", {24'b0, mem[1][15:8]}, 32'hAB);

    // Both ports requesting every opportunity: grants must alternate.
    for (int i = 0; i < 24; i++) begin
      if (!pend[0]) rand_txn(0);
      if (!pend[1]) rand_txn(1);
      apply_inputs();
      step();
    end
    pend = 2'b00; apply_inputs();
    repeat (3) step();

    // Port 1 streams, port 0 joins midway.
    for (int i = 0; i < 12; i++) begin
      if (!pend[1]) rand_txn(1);
      if (i == 5) rand_txn(0);
      apply_inputs();
      step();
    end
    pend = 2'b00; apply_inputs();
    repeat (3) step();

    // Misaligned word load on port 1, then out-of-range store on port 0.
    new_txn(1, 1'b0, 32'h06, 32'h0, 3'b010);
    apply_inputs();
    repeat (3) step();
    new_txn(0, 1'b1, 32'h80, 32'h55AA55AA, 3'b010);
    apply_inputs();
    repeat (3) step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (!pend[0] && $urandom_range(0, 99) < 40) rand_txn(0);
      if (!pend[1] && $urandom_range(0, 99) < 40) rand_txn(1);
      apply_inputs();
      step();
    end
    pend = 2'b00; apply_inputs();
    repeat (3) step();

    // Reset in the middle of a store access.
    new_txn(0, 1'b1, 32'h10, 32'h12345678, 3'b010);
    apply_inputs();
    step();
    old_word = mem[4];
    #2 rst = 1'b1;
    #1;
    check_val("rst_gnt", {30'b0, p1_gnt, p0_gnt}, 32'd0);
    check_val("rst_mem_write", {31'b0, mem_write}, 32'd0);
    check_val("rst_busy", {31'b0, busy}, 32'd0);
    check_val("rst_mem_address", mem_address, 32'd0);
    pend = 2'b00; apply_inputs();
    @(posedge clk);
    @(posedge clk);
    #1;
    check_val("rst_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'd0);
    check_val("rst_no_write", mem[4], old_word);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    check_outputs();
    rand_txn(0);
    rand_txn(1);
    apply_inputs();
    step();
    check_val("rst_rr_p0_first", {31'b0, p0_gnt}, 32'd1);
    repeat (6) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
